cybernid_feature_quantizer: RTL and testbench

- Streaming front-end that encodes raw signed network-traffic features into the 2-bit activation codes consumed by the first LUT neuron layer.
- Accepts one feature per beat over valid/ready and thresholds each against three per-feature programmable thresholds.
- Packs a frame of NUM_FEATURES codes into one vector and presents it to the layer-0 input register with a valid/ready handshake.
- Detects and recovers from frame-length errors.

---
 rtl/cybernid_feature_quantizer.sv | 158 +++++++++++++++
 tb/tb_cybernid_feature_quantizer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cybernid_feature_quantizer.sv
// cybernid_feature_quantizer
// Streaming front-end that turns raw signed traffic features into the 2-bit
// activation codes of the first LUT neuron layer. Each accepted feature is
// compared against three per-feature thresholds; the resulting code is packed
// into a frame vector which is then offered to the layer-0 input register.
// Frames that end early (short) or run past NUM_FEATURES beats (long) are
// still emitted, flagged with err_len and counted in err_cnt.
//
// Ports:
//   clk, rst_n            clock (rising edge) and async active-low reset
//   in_feat/in_valid/in_last/in_ready   feature stream in
//   out_vec/out_valid/out_ready         packed code vector out
//   cfg_we/cfg_idx/cfg_sel/cfg_data     threshold write port
//   err_len               one-cycle pulse on a frame-length error
//   err_cnt               saturating count of length errors
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload until that edge, and
// ready never depends combinationally on valid.

module cybernid_feature_quantizer #(
  parameter int NUM_FEATURES = 16,
  parameter int FEAT_W       = 16,
  parameter int IDX_W        = $clog2(NUM_FEATURES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [FEAT_W-1:0]  in_feat,
  input  logic                      in_valid,
  input  logic                      in_last,
  output logic                      in_ready,
  output logic [2*NUM_FEATURES-1:0] out_vec,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      cfg_we,
  input  logic [IDX_W-1:0]          cfg_idx,
  input  logic [1:0]                cfg_sel,
  input  logic signed [FEAT_W-1:0]  cfg_data,
  output logic                      err_len,
  output logic [7:0]                err_cnt
);

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DROP    = 2'd2;

  localparam logic signed [FEAT_W-1:0] T0_RST = FEAT_W'(-(1 << (FEAT_W-2)));
  localparam logic signed [FEAT_W-1:0] T1_RST = '0;
  localparam logic signed [FEAT_W-1:0] T2_RST = FEAT_W'(1 << (FEAT_W-2));
  localparam logic [IDX_W-1:0]         LAST_SLOT = IDX_W'(NUM_FEATURES-1);

  logic [1:0]               state;
  logic [IDX_W-1:0]         count;
  logic                     drop_last;  // in_last already consumed while in DROP
  logic signed [FEAT_W-1:0] thr0 [NUM_FEATURES];
  logic signed [FEAT_W-1:0] thr1 [NUM_FEATURES];
  logic signed [FEAT_W-1:0] thr2 [NUM_FEATURES];

  logic       accept;
  logic       out_take;
  logic [1:0] code;
  logic       last_done;

  assign in_ready = (state == ST_COLLECT) || (state == ST_DROP);
  assign accept   = in_valid && in_ready;
  assign out_take = out_valid && out_ready;

  // Count of thresholds passed, so non-monotonic thresholds still give 0..3.
  // Reads the thresholds before any same-edge write lands.
  assign code = 2'(in_feat >= thr0[count]) + 2'(in_feat >= thr1[count])
              + 2'(in_feat >= thr2[count]);

  // In DROP the frame is finished once the closing beat has gone by, now or earlier.
  assign last_done = drop_last || (accept && in_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_COLLECT;
      count     <= '0;
      drop_last <= 1'b0;
      out_vec   <= '0;
      out_valid <= 1'b0;
      err_len   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_len <= 1'b0;
      case (state)
        ST_COLLECT: begin
          if (accept) begin
            out_vec[{count, 1'b0} +: 2] <= code;
            if (in_last) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              if (count != LAST_SLOT) begin
                err_len <= 1'b1;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
              end
            end else if (count == LAST_SLOT) begin
              state     <= ST_DROP;
              out_valid <= 1'b1;
              drop_last <= 1'b0;
              err_len   <= 1'b1;
              if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (out_take) begin
            state     <= ST_COLLECT;
            out_valid <= 1'b0;
            count     <= '0;
            out_vec   <= '0;
          end
        end
        ST_DROP: begin
          // Overrun beats are swallowed; only the frame end is remembered.
          if (out_take) begin
            out_valid <= 1'b0;
            count     <= '0;
            out_vec   <= '0;
          end
          if (accept && in_last) drop_last <= 1'b1;
          // out_valid low here means the vector has already been taken.
          if (last_done && (!out_valid || out_ready)) begin
            state     <= ST_COLLECT;
            drop_last <= 1'b0;
          end
        end
        default: begin
          state     <= ST_COLLECT;
          out_valid <= 1'b0;
          count     <= '0;
          out_vec   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FEATURES; i++) begin
        thr0[i] <= T0_RST;
        thr1[i] <= T1_RST;
        thr2[i] <= T2_RST;
      end
    end else if (cfg_we && (32'(cfg_idx) < NUM_FEATURES)) begin
      case (cfg_sel)
        2'd0:    thr0[cfg_idx] <= cfg_data;
        2'd1:    thr1[cfg_idx] <= cfg_data;
        2'd2:    thr2[cfg_idx] <= cfg_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cybernid_feature_quantizer.sv
module tb_cybernid_feature_quantizer;

  localparam int NF = 16;
  localparam int FW = 16;

  logic                 clk;
  logic                 rst_n;
  logic signed [FW-1:0] in_feat;
  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [2*NF-1:0]      out_vec;
  logic                 out_valid;
  logic                 out_ready;
  logic                 cfg_we;
  logic [3:0]           cfg_idx;
  logic [1:0]           cfg_sel;
  logic signed [FW-1:0] cfg_data;
  logic                 err_len;
  logic [7:0]           err_cnt;

  cybernid_feature_quantizer #(.NUM_FEATURES(NF), .FEAT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_feat(in_feat), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_vec(out_vec), .out_valid(out_valid), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .err_len(err_len), .err_cnt(err_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int err_pulses;
  logic [2*NF-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // scoreboard: every output handshake must match the next expected vector
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual=0x%08h required=none", out_vec);
      end else begin
        logic [2*NF-1:0] e;
        e = exp_q.pop_front();
        if (out_vec !== e) begin
          failures++;
          $display("FAIL sb_vec actual=0x%08h required=0x%08h", out_vec, e);
        end
      end
    end
    if (rst_n && err_len) err_pulses++;
  end

  // driver tasks (all called at #1 after a rising edge)
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic signed [FW-1:0] f, input bit last);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_feat = f; in_last = last;
    while (!in_ready && guard < 100) begin step(); guard++; end
    if (guard >= 100) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int idx, input logic signed [FW-1:0] v,
                            input logic signed [FW-1:0] fill, input int nbeats);
    for (int b = 0; b < nbeats; b++) send_beat((b == idx) ? v : fill, b == nbeats-1);
  endtask

  task automatic take_frame(input logic [2*NF-1:0] e);
    exp_q.push_back(e);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("out_valid_after_take", 32'(out_valid), 32'd0);
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [1:0] sel, input logic signed [FW-1:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  typedef struct {
    int                   idx;
    logic signed [FW-1:0] val;
    logic signed [FW-1:0] fill;
    logic [31:0]          exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    checks = 0; failures = 0; err_pulses = 0;
    in_feat = '0; in_valid = 0; in_last = 0; out_ready = 0;
    cfg_we = 0; cfg_idx = '0; cfg_sel = '0; cfg_data = '0;

    tbl[0] = '{0, -16'sd20000, 16'sd0,      32'hAAAAAAA8};
    tbl[1] = '{0, -16'sd1,     16'sd0,      32'hAAAAAAA9};
    tbl[2] = '{0, 16'sd0,      16'sd0,      32'hAAAAAAAA};
    tbl[3] = '{0, 16'sd16384,  16'sd0,      32'hAAAAAAAB};
    tbl[4] = '{15, -16'sd32768, 16'sd20000, 32'h3FFFFFFF};
    tbl[5] = '{7, 16'sd16383,  -16'sd16384, 32'h55559555};

    rst_n = 1'b0;
    #23 rst_n = 1'b1;
    step();
    chk("rst_out_vec", out_vec, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_err_len", 32'(err_len), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // exact-length frames from the table
    for (int r = 0; r < 6; r++) begin
      send_frame(tbl[r].idx, tbl[r].val, tbl[r].fill, NF);
      chk("tbl_out_valid", 32'(out_valid), 32'd1);
      chk("tbl_out_vec", out_vec, tbl[r].exp);
      chk("tbl_in_ready_hold", 32'(in_ready), 32'd0);
      take_frame(tbl[r].exp);
    end
    chk("tbl_err_pulses", 32'(err_pulses), 32'd0);
    chk("tbl_err_cnt", 32'(err_cnt), 32'd0);

    // backpressure: hold the vector for 10 cycles
    send_frame(0, 16'sd16384, 16'sd0, NF);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_vec", out_vec, 32'hAAAAAAAB);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    take_frame(32'hAAAAAAAB);
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    send_frame(0, -16'sd1, 16'sd0, NF);
    chk("bp_next_vec", out_vec, 32'hAAAAAAA9);
    take_frame(32'hAAAAAAA9);

    // short frame: last on beat 4
    send_frame(-1, 16'sd0, 16'sd20000, 5);
    chk("short_err_len", 32'(err_len), 32'd1);
    chk("short_err_cnt", 32'(err_cnt), 32'd1);
    chk("short_vec", out_vec, 32'h000003FF);
    take_frame(32'h000003FF);
    chk("short_err_len_off", 32'(err_len), 32'd0);

    // long frame: 20 beats, codes i%4 in beats 0..15, overrun beats code 3
    for (int b = 0; b < NF; b++) begin
      case (b % 4)
        0: send_beat(-16'sd20000, 1'b0);
        1: send_beat(-16'sd1, 1'b0);
        2: send_beat(16'sd0, 1'b0);
        default: send_beat(16'sd20000, 1'b0);
      endcase
    end
    chk("long_err_len", 32'(err_len), 32'd1);
    chk("long_err_cnt", 32'(err_cnt), 32'd2);
    chk("long_out_valid", 32'(out_valid), 32'd1);
    chk("long_in_ready", 32'(in_ready), 32'd1);
    for (int b = NF; b < 19; b++) send_beat(16'sd20000, 1'b0);
    chk("long_vec_held", out_vec, 32'hE4E4E4E4);
    exp_q.push_back(32'hE4E4E4E4);
    out_ready = 1'b1;
    send_beat(16'sd20000, 1'b1);
    out_ready = 1'b0;
    chk("long_done_out_valid", 32'(out_valid), 32'd0);
    chk("long_done_in_ready", 32'(in_ready), 32'd1);
    send_frame(0, 16'sd0, 16'sd0, NF);
    chk("long_next_vec", out_vec, 32'hAAAAAAAA);
    take_frame(32'hAAAAAAAA);
    chk("long_next_err_cnt", 32'(err_cnt), 32'd2);
    chk("pre_rst_err_pulses", 32'(err_pulses), 32'd2);

    // configuration: T1 of feature 3 = 100
    cfg_write(4'd3, 2'd1, 16'sd100);
    send_frame(3, 16'sd99, 16'sd0, NF);
    chk("cfg_x99", out_vec, 32'hAAAAAA6A);
    take_frame(32'hAAAAAA6A);
    send_frame(3, 16'sd100, 16'sd0, NF);
    chk("cfg_x100", out_vec, 32'hAAAAAAAA);
    take_frame(32'hAAAAAAAA);
    // same-edge write: restore T1=0, then write 100 while feature 3 (x=50) is accepted
    cfg_write(4'd3, 2'd1, 16'sd0);
    for (int b = 0; b < NF; b++) begin
      if (b == 3) begin
        cfg_we = 1'b1; cfg_idx = 4'd3; cfg_sel = 2'd1; cfg_data = 16'sd100;
        send_beat(16'sd50, 1'b0);
        cfg_we = 1'b0;
      end else begin
        send_beat(16'sd0, b == NF-1);
      end
    end
    chk("cfg_same_cycle_old", out_vec, 32'hAAAAAAAA);
    take_frame(32'hAAAAAAAA);
    send_frame(3, 16'sd50, 16'sd0, NF);
    chk("cfg_new_applied", out_vec, 32'hAAAAAA6A);
    take_frame(32'hAAAAAA6A);
    cfg_write(4'd3, 2'd3, 16'sd32767);
    send_frame(-1, 16'sd0, 16'sd20000, NF);
    chk("cfg_sel3_ignored", out_vec, 32'hFFFFFFFF);
    take_frame(32'hFFFFFFFF);

    // async reset during beat 7
    send_frame(-1, 16'sd0, 16'sd20000, 7);
    chk("mid_partial_vec", out_vec, 32'h00003FFF);
    in_valid = 1'b1; in_feat = 16'sd20000;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_vec", out_vec, 32'h0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_err_cnt", 32'(err_cnt), 32'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    // T1 of feature 3 back to 0: x=50 gives code 2
    send_frame(3, 16'sd50, 16'sd0, NF);
    chk("post_rst_vec", out_vec, 32'hAAAAAAAA);
    chk("post_rst_err_cnt", 32'(err_cnt), 32'd0);
    take_frame(32'hAAAAAAAA);

    // 300 one-beat frames: err_cnt saturates
    out_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      exp_q.push_back(32'h00000002);
      send_beat(16'sd0, 1'b1);
    end
    step();
    out_ready = 1'b0;
    chk("sat_err_cnt", 32'(err_cnt), 32'd255);
    chk("sat_err_pulses", 32'(err_pulses), 32'd302);

    begin
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin step(); guard++; end
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
